ipi_mailbox_rx_drain: RTL

//  Per-core CSR master that sits downstream of one ipi_mailbox CSR port and its ipi_irq line.

---
 rtl/ipi_mailbox_rx_drain.sv | 72 +++++++
 1 files changed

// File: rtl/ipi_mailbox_rx_drain.sv
// ipi_mailbox_rx_drain: drains mailbox RX_DATA over CSR reads into a valid/ready word stream
module ipi_mailbox_rx_drain #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE = '0,
  parameter int CNT_W = 16,
  parameter int FLT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              ipi_irq,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [DATA_W-1:0] rsp_rdata,
  input  logic              rsp_fault,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  drain_count,
  output logic [FLT_W-1:0]  fault_count
);
  localparam logic [ADDR_W-1:0] RX_ADDR = BASE + ADDR_W'(8);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t state, state_n;
  logic out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic buf_free, rsp_ok, rsp_err;
  assign buf_free = !out_valid_q || out_ready;
  assign rsp_ok = state == RSP && rsp_valid && !rsp_fault;
  assign rsp_err = state == RSP && rsp_valid && rsp_fault;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (enable && ipi_irq && buf_free) state_n = REQ;
      REQ: if (req_ready) state_n = RSP;
      RSP: if (rsp_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign req_valid = state == REQ;
  assign req_write = 1'b0;
  assign req_addr = req_valid ? RX_ADDR : '0;
  assign req_wdata = '0;
  assign rsp_ready = state == RSP;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      drain_count <= '0;
      fault_count <= '0;
    end else begin
      state <= state_n;
      if (rsp_ok) begin
        out_valid_q <= 1'b1;
        out_data_q <= rsp_rdata;
        drain_count <= drain_count + 1'b1;
      end else if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (rsp_err && !(&fault_count)) fault_count <= fault_count + 1'b1;
    end
  end
endmodule
